and_gate_p: RTL and testbench

//   Two-input bitwise AND primitive with a registered shadow of its result.

---
 rtl/and_gate_p_pkg.sv | 23 ++
 rtl/and_gate_p_edge.sv | 35 +++
 rtl/and_gate_p.sv | 58 +++++
 tb/tb_and_gate_p.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/and_gate_p_pkg.sv
// rtl/and_gate_p_pkg.sv - shared defaults and saturating-increment helper for and_gate_p
//
// Purpose : default parameter values for and_gate_p and the counter helper.
// Contents: DEF_WIDTH, DEF_CNT_WIDTH, MAX_CNT_WIDTH, sat_inc().

package and_gate_p_pkg;

  localparam int DEF_WIDTH     = 1;
  localparam int DEF_CNT_WIDTH = 8;

  // Widest counter the helper supports; callers zero-extend into it.
  localparam int MAX_CNT_WIDTH = 32;

  // Returns cnt + 1, clamped at max. The caller passes its own all-ones
  // value as max, so one helper serves every counter width.
  function automatic logic [MAX_CNT_WIDTH-1:0] sat_inc(
    input logic [MAX_CNT_WIDTH-1:0] cnt,
    input logic [MAX_CNT_WIDTH-1:0] max
  );
    return (cnt >= max) ? cnt : cnt + MAX_CNT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/and_gate_p_edge.sv
// rtl/and_gate_p_edge.sv - one-bit registered shadow with rise/fall edge pulses
//
// Purpose: registers d and flags 0->1 / 1->0 transitions of d relative to
//          the previously registered value.
// Ports  : clk  - rising-edge clock
//          rst  - asynchronous active-high reset (clears q, rise, fall)
//          d    - bit to track
//          q    - d delayed by one clock
//          rise - one-cycle pulse when d goes 0->1
//          fall - one-cycle pulse when d goes 1->0

module and_gate_p_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  // q doubles as the previous-value register, so the first edge after reset
  // compares d against 0: a high d gives a rise pulse, fall cannot assert.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q    <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      q    <= d;
      rise <= d & ~q;
      fall <= ~d & q;
    end
  end

endmodule

// File: rtl/and_gate_p.sv
// rtl/and_gate_p.sv - bitwise AND gate with registered shadow, edge pulses and all-ones counter
//
// Purpose: c = a & b combinationally (valid with no clock and during reset);
//          the clocked side keeps a registered copy, per-bit edge pulses and
//          a saturating count of cycles where every bit of c is 1.
// Ports  : clk    - rising-edge clock
//          rst    - asynchronous active-high reset for all registers
//          a, b   - operands, WIDTH bits
//          c      - a & b, WIDTH bits, zero latency
//          c_q    - c registered, WIDTH bits
//          c_rise - per-bit 0->1 pulse of c, WIDTH bits
//          c_fall - per-bit 1->0 pulse of c, WIDTH bits
//          hi_cnt - saturating count of cycles with &c == 1, CNT_WIDTH bits

module and_gate_p
  import and_gate_p_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [WIDTH-1:0]     c,
  output logic [WIDTH-1:0]     c_q,
  output logic [WIDTH-1:0]     c_rise,
  output logic [WIDTH-1:0]     c_fall,
  output logic [CNT_WIDTH-1:0] hi_cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  // Plain continuous assign keeps c independent of clk and rst and lets
  // X/Z propagate with ordinary & semantics.
  assign c = a & b;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    and_gate_p_edge u_edge (
      .clk  (clk),
      .rst  (rst),
      .d    (c[i]),
      .q    (c_q[i]),
      .rise (c_rise[i]),
      .fall (c_fall[i])
    );
  end

  // Only rst clears the counter; it sticks at all-ones once reached.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_cnt <= '0;
    end else if (&c) begin
      hi_cnt <= CNT_WIDTH'(sat_inc(MAX_CNT_WIDTH'(hi_cnt), MAX_CNT_WIDTH'(CNT_MAX)));
    end
  end

endmodule

// File: tb/tb_and_gate_p.sv
// tb/tb_and_gate_p.sv - scoreboard bench for and_gate_p (WIDTH 1 and WIDTH 4 instances)

module tb_and_gate_p;

  logic       clk = 1'b0;
  logic       clk_en = 1'b0;
  logic       rst = 1'b0;
  logic       a1 = 1'b0, b1 = 1'b0;
  logic       c1, c_q1, c_rise1, c_fall1;
  logic [7:0] hi_cnt1;
  logic [3:0] a4 = 4'h0, b4 = 4'h0;
  logic [3:0] c4, c_q4, c_rise4, c_fall4;
  logic [7:0] hi_cnt4;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    bit         sel;   // 0: one-bit instance, 1: four-bit instance
    bit         regs;  // also check registered outputs
    logic [3:0] c;
    logic [3:0] c_q;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];
  event sample_ev;

  and_gate_p #(.WIDTH(1), .CNT_WIDTH(8)) dut1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .c(c1), .c_q(c_q1),
    .c_rise(c_rise1), .c_fall(c_fall1), .hi_cnt(hi_cnt1)
  );

  and_gate_p #(.WIDTH(4), .CNT_WIDTH(8)) dut4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .c(c4), .c_q(c_q4),
    .c_rise(c_rise4), .c_fall(c_fall4), .hi_cnt(hi_cnt4)
  );

  // Clock only runs once clk_en is set, so the first tests see a dead clock.
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  // Monitor: pops expectations and compares against the selected instance.
  initial begin : monitor
    exp_t       e;
    logic [3:0] ac, aq, ar, af;
    logic [7:0] acnt;
    bit         bad;
    forever begin
      @(sample_ev);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.sel) begin
          ac = c4; aq = c_q4; ar = c_rise4; af = c_fall4; acnt = hi_cnt4;
        end else begin
          ac = {3'b000, c1}; aq = {3'b000, c_q1}; ar = {3'b000, c_rise1};
          af = {3'b000, c_fall1}; acnt = hi_cnt1;
        end
        bad = (ac !== e.c);
        if (e.regs && ({aq, ar, af, acnt} !== {e.c_q, e.rise, e.fall, e.cnt})) bad = 1'b1;
        checks++;
        if (bad) begin
          errors++;
          $display("FAIL %s: got c=%b c_q=%b rise=%b fall=%b hi_cnt=%0d, expected c=%b c_q=%b rise=%b fall=%b hi_cnt=%0d (regs checked=%0d)",
                   e.name, ac, aq, ar, af, acnt, e.c, e.c_q, e.rise, e.fall, e.cnt, e.regs);
        end
      end
    end
  end

  task automatic expect_state(input string name, input bit sel, input bit regs,
                              input logic [3:0] c, input logic [3:0] c_q,
                              input logic [3:0] rise, input logic [3:0] fall,
                              input logic [7:0] cnt);
    exp_t e;
    e.name = name; e.sel = sel; e.regs = regs;
    e.c = c; e.c_q = c_q; e.rise = rise; e.fall = fall; e.cnt = cnt;
    sb.push_back(e);
    ->sample_ev;
    #1;
  endtask

  // One rising edge, then return at the following falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin : stim
    logic [1:0] v;
    logic [3:0] tt_exp [4] = '{4'd0, 4'd0, 4'd0, 4'd1};

    // 1: truth table, no clock
    for (int i = 0; i < 4; i++) begin
      v = 2'(i);
      a1 = v[1]; b1 = v[0];
      #5;
      expect_state($sformatf("truth_%0d%0d", v[1], v[0]), 1'b0, 1'b0, tt_exp[i], 4'd0, 4'd0, 4'd0, 8'd0);
      #4;
    end
    a1 = 1'b0; b1 = 1'bx; #2;
    expect_state("x_and_0", 1'b0, 1'b0, 4'b0000, 4'd0, 4'd0, 4'd0, 8'd0);
    a1 = 1'b1; #2;
    expect_state("x_and_1", 1'b0, 1'b0, 4'b000x, 4'd0, 4'd0, 4'd0, 8'd0);

    // 2: reset isolation
    rst = 1'b1; a1 = 1'b1; b1 = 1'b1; a4 = 4'hF; b4 = 4'hF;
    #2;
    expect_state("reset_iso_w1", 1'b0, 1'b1, 4'd1, 4'd0, 4'd0, 4'd0, 8'd0);
    expect_state("reset_iso_w4", 1'b1, 1'b1, 4'hF, 4'd0, 4'd0, 4'd0, 8'd0);
    a4 = 4'h0; b4 = 4'h0;

    // 3: edges after reset release
    rst = 1'b0; #1;
    expect_state("released_no_edge", 1'b0, 1'b1, 4'd1, 4'd0, 4'd0, 4'd0, 8'd0);
    clk_en = 1'b1;
    step();
    expect_state("edge1_rise", 1'b0, 1'b1, 4'd1, 4'd1, 4'd1, 4'd0, 8'd1);
    step();
    expect_state("edge2_no_rise", 1'b0, 1'b1, 4'd1, 4'd1, 4'd0, 4'd0, 8'd2);
    step();
    expect_state("edge3", 1'b0, 1'b1, 4'd1, 4'd1, 4'd0, 4'd0, 8'd3);
    b1 = 1'b0; #1;
    expect_state("b_drop_comb", 1'b0, 1'b1, 4'd0, 4'd1, 4'd0, 4'd0, 8'd3);
    step();
    expect_state("fall_pulse", 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd1, 8'd3);
    step();
    expect_state("fall_gone", 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 8'd3);

    // 4: counter saturation over 300 cycles
    b1 = 1'b1;
    for (int i = 0; i < 251; i++) step();
    expect_state("cnt_254", 1'b0, 1'b1, 4'd1, 4'd1, 4'd0, 4'd0, 8'd254);
    step();
    expect_state("cnt_255", 1'b0, 1'b1, 4'd1, 4'd1, 4'd0, 4'd0, 8'd255);
    for (int i = 0; i < 48; i++) step();
    expect_state("cnt_sat_hold", 1'b0, 1'b1, 4'd1, 4'd1, 4'd0, 4'd0, 8'd255);
    b1 = 1'b0;
    step();
    expect_state("cnt_hold_low", 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd1, 8'd255);
    step();
    expect_state("cnt_hold_low2", 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 8'd255);

    // 5: asynchronous reset between edges
    b1 = 1'b1;
    step();
    expect_state("pre_async_rst", 1'b0, 1'b1, 4'd1, 4'd1, 4'd1, 4'd0, 8'd255);
    #1 rst = 1'b1;
    #1;
    expect_state("async_rst_clear", 1'b0, 1'b1, 4'd1, 4'd0, 4'd0, 4'd0, 8'd0);
    step();
    expect_state("rst_held_edge", 1'b0, 1'b1, 4'd1, 4'd0, 4'd0, 4'd0, 8'd0);
    a1 = 1'b0;
    rst = 1'b0;

    // 6: four-bit instance
    a4 = 4'b1100; b4 = 4'b1010; #1;
    expect_state("w4_comb", 1'b1, 1'b1, 4'b1000, 4'd0, 4'd0, 4'd0, 8'd0);
    step();
    expect_state("w4_partial_edge", 1'b1, 1'b1, 4'b1000, 4'b1000, 4'b1000, 4'd0, 8'd0);
    a4 = 4'hF; b4 = 4'hF;
    step();
    expect_state("w4_all_ones_1", 1'b1, 1'b1, 4'hF, 4'hF, 4'b0111, 4'd0, 8'd1);
    step();
    expect_state("w4_all_ones_2", 1'b1, 1'b1, 4'hF, 4'hF, 4'd0, 4'd0, 8'd2);
    step();
    expect_state("w4_all_ones_3", 1'b1, 1'b1, 4'hF, 4'hF, 4'd0, 4'd0, 8'd3);
    a4 = 4'h0;
    step();
    expect_state("w4_fall_all", 1'b1, 1'b1, 4'h0, 4'h0, 4'd0, 4'hF, 8'd3);

    #2;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
